// File: rtl/gnr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gnr_pkg
//  Description : Shared constants, state encoding and filler-slot definition
//                for the GRN result reader.
//                  GNR_LINE_W - FIFO line width (two record slots per line)
//                  GNR_SLOT_W - width of one record slot (record + zero pad)
//                  GNR_REC_W  - record payload width, low bits of a slot
//                  GNR_CNT_W  - width of line and record counters
//  Revision    : 1.0 - initial release
// ============================================================================
package gnr_pkg;

    localparam int GNR_LINE_W = 512;
    localparam int GNR_SLOT_W = 256;
    localparam int GNR_REC_W  = 246;
    localparam int GNR_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A slot carries no record when every bit, pad included, is zero.
    function automatic logic gnr_is_filler(input logic [GNR_SLOT_W-1:0] slot);
        return (slot == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnr_slot_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : gnr_slot_unpacker
//  Description : Holds one FIFO line, walks its two slots in order (low slot
//                first), skips filler slots in a single cycle and drives a
//                registered valid/ready record stream.
//  Ports       : i_load/i_line    - capture a new line into the buffer
//                i_last_line      - buffered line is the final line of the run
//                o_buf_empty      - line buffer holds no unexamined slot
//                o_rec_valid/i_rec_ready/o_rec_data/o_rec_last - record stream
//  Revision    : 1.0 - initial release
// ============================================================================
module gnr_slot_unpacker
    import gnr_pkg::*;
#(
    parameter int LINE_WIDTH = GNR_LINE_W,
    parameter int SLOT_WIDTH = GNR_SLOT_W,
    parameter int REC_WIDTH  = GNR_REC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [LINE_WIDTH-1:0] i_line,
    input  logic                  i_last_line,
    output logic                  o_buf_empty,
    output logic                  o_rec_valid,
    input  logic                  i_rec_ready,
    output logic [REC_WIDTH-1:0]  o_rec_data,
    output logic                  o_rec_last
);

    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  full_q, full_d;
    logic                  idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [REC_WIDTH-1:0]  data_q, data_d;
    logic                  last_q, last_d;

    logic [SLOT_WIDTH-1:0] w_slot;
    logic [SLOT_WIDTH-1:0] w_slot_hi;
    logic                  w_filler;
    logic                  w_out_free;

    assign w_slot_hi  = line_q[2*SLOT_WIDTH-1:SLOT_WIDTH];
    assign w_slot     = idx_q ? w_slot_hi : line_q[SLOT_WIDTH-1:0];
    assign w_filler   = gnr_is_filler(w_slot);
    // The output register can take a new record if it is empty or its
    // current record transfers this cycle.
    assign w_out_free = !valid_q || i_rec_ready;

    always_comb begin
        line_d = line_q;
        full_d = full_q;
        idx_d  = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;

        if (valid_q && i_rec_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (i_load) begin
            line_d = i_line;
            full_d = 1'b1;
            idx_d  = 1'b0;
        end else if (full_q && (w_filler || w_out_free)) begin
            if (!w_filler) begin
                valid_d = 1'b1;
                data_d  = w_slot[REC_WIDTH-1:0];
                // From the low slot, the record is final only if the high
                // slot behind it is filler.
                last_d  = i_last_line && (idx_q || gnr_is_filler(w_slot_hi));
            end
            if (idx_q) begin
                full_d = 1'b0;
            end else begin
                idx_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q  <= '0;
            full_q  <= 1'b0;
            idx_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            line_q  <= line_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign o_buf_empty = !full_q;
    assign o_rec_valid = valid_q;
    assign o_rec_data  = data_q;
    assign o_rec_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/gnr_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gnr_result_reader
//  Description : Pops 512-bit result lines from the GRN output FIFO, splits
//                them into 256-bit slots, drops filler slots and streams the
//                246-bit records downstream. Raises done once the programmed
//                number of lines has been consumed and fully drained.
//  Ports       : start/num_lines  - launch a run of num_lines lines
//                fifo_*           - FIFO read side (data one cycle after pop)
//                rec_*            - record valid/ready stream, rec_count total
//                done             - run complete, held until rst
//  Revision    : 1.0 - initial release
// ============================================================================
module gnr_result_reader
    import gnr_pkg::*;
#(
    parameter int LINE_WIDTH = GNR_LINE_W,
    parameter int SLOT_WIDTH = GNR_SLOT_W,
    parameter int REC_WIDTH  = GNR_REC_W,
    parameter int CNT_WIDTH  = GNR_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_lines,
    input  logic                  fifo_empty,
    input  logic [LINE_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [REC_WIDTH-1:0]  rec_data,
    output logic                  rec_last,
    output logic [CNT_WIDTH-1:0]  rec_count,
    output logic                  done
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = 1;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_lines_q, num_lines_d;
    logic [CNT_WIDTH-1:0]  lines_req_q, lines_req_d;
    logic [CNT_WIDTH-1:0]  lines_got_q, lines_got_d;
    logic [CNT_WIDTH-1:0]  rec_count_q, rec_count_d;
    logic                  pend_q, pend_d;
    logic                  rd_en_q, rd_en_d;
    logic                  cap_q, cap_d;

    logic                  w_buf_empty;
    logic                  w_last_line;
    logic                  w_fetch_ok;

    // Every line has arrived and nothing is in flight from the FIFO.
    assign w_last_line = (lines_got_q == num_lines_q) && !pend_q;

    // Pending covers both the pop cycle and the capture cycle, so at most
    // one line is ever in flight and the buffer is never overwritten.
    assign w_fetch_ok  = (state_q == ST_RUN) && !fifo_empty &&
                         (lines_req_q < num_lines_q) && w_buf_empty && !pend_q;

    always_comb begin
        state_d     = state_q;
        num_lines_d = num_lines_q;
        lines_req_d = lines_req_q;
        lines_got_d = lines_got_q;
        rec_count_d = rec_count_q;
        pend_d      = pend_q;
        rd_en_d     = 1'b0;
        cap_d       = rd_en_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_lines_d = num_lines;
                    lines_req_d = '0;
                    lines_got_d = '0;
                    rec_count_d = '0;
                    state_d     = (num_lines == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fetch_ok) begin
                    rd_en_d     = 1'b1;
                    pend_d      = 1'b1;
                    lines_req_d = lines_req_q + c_cnt_one;
                end
                if (cap_q) begin
                    pend_d      = 1'b0;
                    lines_got_d = lines_got_q + c_cnt_one;
                end
                if (rec_valid && rec_ready) begin
                    rec_count_d = rec_count_q + c_cnt_one;
                end
                // Finish only once the last record has left the output register.
                if (w_last_line && w_buf_empty && !rec_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_lines_q <= '0;
            lines_req_q <= '0;
            lines_got_q <= '0;
            rec_count_q <= '0;
            pend_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_lines_q <= num_lines_d;
            lines_req_q <= lines_req_d;
            lines_got_q <= lines_got_d;
            rec_count_q <= rec_count_d;
            pend_q      <= pend_d;
            rd_en_q     <= rd_en_d;
            cap_q       <= cap_d;
        end
    end

    gnr_slot_unpacker #(
        .LINE_WIDTH (LINE_WIDTH),
        .SLOT_WIDTH (SLOT_WIDTH),
        .REC_WIDTH  (REC_WIDTH)
    ) u_unpacker (
        .clk         (clk),
        .rst         (rst),
        .i_load      (cap_q),
        .i_line      (fifo_rd_data),
        .i_last_line (w_last_line),
        .o_buf_empty (w_buf_empty),
        .o_rec_valid (rec_valid),
        .i_rec_ready (rec_ready),
        .o_rec_data  (rec_data),
        .o_rec_last  (rec_last)
    );

    assign fifo_rd_en = rd_en_q;
    assign rec_count  = rec_count_q;
    assign done       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gnr_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gnr_result_reader
//  Description : Self-checking bench for gnr_result_reader. Stimulus fills a
//                FIFO model with random lines and pushes the records each run
//                must yield into a scoreboard; a monitor pops and compares on
//                every record handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gnr_result_reader;

    localparam int LW = 512;
    localparam int SW = 256;
    localparam int RW = 246;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_lines = '0;
    logic          fifo_empty = 1'b1;
    logic [LW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          rec_valid;
    logic          rec_ready = 1'b1;
    logic [RW-1:0] rec_data;
    logic          rec_last;
    logic [CW-1:0] rec_count;
    logic          done;

    always #5 clk = ~clk;

    gnr_result_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_lines    (num_lines),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_data     (rec_data),
        .rec_last     (rec_last),
        .rec_count    (rec_count),
        .done         (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [LW-1:0] fifo_q[$];
    bit            force_empty = 1'b0;
    int            pops = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_on_empty: got pop expected none");
            end else begin
                fifo_rd_data <= fifo_q.pop_front();
                pops++;
            end
        end
    end

    always @(negedge clk) fifo_empty = force_empty || (fifo_q.size() == 0);

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [RW-1:0] data;
        logic          last;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          e;
    bit            prev_stall = 1'b0;
    logic [RW-1:0] prev_data;
    int            lasts_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", rec_valid, 1'b1);
                check("hold_data", rec_data, prev_data);
            end
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rec: got %0h expected none", rec_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rec_data", rec_data, e.data);
                    check("rec_last", rec_last, e.last);
                end
                if (rec_last) lasts_seen++;
            end
            prev_stall = rec_valid && !rec_ready;
            prev_data  = rec_data;
        end
    end

    // ---------------- ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    int stall_cycles = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_cycles > 0) begin
            rec_ready = 1'b0;
            stall_cycles--;
        end else begin
            case (ready_mode)
                0:       rec_ready = 1'b1;
                1:       rec_ready = ~rec_ready;
                default: rec_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [SW-1:0] rand_slot(input bit allow_filler);
        logic [SW-1:0] s;
        s = '0;
        if (allow_filler && ($urandom_range(0, 3) == 0)) return s;
        for (int w = 0; w < SW / 32; w++) s[w*32 +: 32] = $urandom;
        s[SW-1:RW] = '0;
        s[$urandom_range(0, RW - 1)] = 1'b1;
        return s;
    endfunction

    int exp_recs;
    int exp_lasts;

    // Queue lines into the FIFO and predict the records: every non-filler
    // slot in line order, low slot first; the final record carries last only
    // when it comes from the final line.
    task automatic load_lines(input logic [LW-1:0] lines[$]);
        rec_t r;
        bit   final_has_rec;
        exp_recs = 0;
        final_has_rec = 1'b0;
        for (int i = 0; i < lines.size(); i++) begin
            for (int s = 0; s < 2; s++) begin
                logic [SW-1:0] sl;
                sl = lines[i][s*SW +: SW];
                if (sl != '0) begin
                    r.data = sl[RW-1:0];
                    r.last = 1'b0;
                    exp_q.push_back(r);
                    exp_recs++;
                    if (i == lines.size() - 1) final_has_rec = 1'b1;
                end
            end
            fifo_q.push_back(lines[i]);
        end
        if (final_has_rec) exp_q[exp_q.size()-1].last = 1'b1;
        exp_lasts = final_has_rec ? 1 : 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        lasts_seen = 0;
        pops = 0;
        force_empty = 1'b0;
    endtask

    task automatic start_run(input int n);
        @(posedge clk);
        #1 start = 1'b1; num_lines = CW'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, done, 1'b1);
    endtask

    task automatic end_run(input string name, input int n_pops);
        @(negedge clk);
        check({name, "_count"}, rec_count, SW'(exp_recs));
        check({name, "_pops"}, pops, SW'(n_pops));
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_lasts"}, lasts_seen, SW'(exp_lasts));
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pops >= n) break;
        end
        check("wait_pops", (pops >= n), 1'b1);
    endtask

    // ---------------- main sequence ----------------
    logic [LW-1:0] lines[$];
    int            rd_seen;
    int            pops_at;

    initial begin
        // reset state
        do_reset();
        @(negedge clk);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_valid", rec_valid, 1'b0);
        check("rst_last", rec_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", rec_data, '0);
        check("rst_count", rec_count, '0);

        // three full lines, always ready
        lines.delete();
        for (int i = 0; i < 3; i++) lines.push_back({rand_slot(0), rand_slot(0)});
        load_lines(lines);
        ready_mode = 0;
        start_run(3);
        wait_done("t1_done", 200);
        end_run("t1", 3);

        // second line's high slot is filler
        do_reset();
        lines.delete();
        lines.push_back({rand_slot(0), rand_slot(0)});
        lines.push_back({{SW{1'b0}}, rand_slot(0)});
        load_lines(lines);
        start_run(2);
        wait_done("t2_done", 200);
        end_run("t2", 2);

        // random lines with fillers, toggling ready and an 8-cycle stall
        do_reset();
        lines.delete();
        for (int i = 0; i < 6; i++) lines.push_back({rand_slot(1), rand_slot(1)});
        lines[5] = {rand_slot(0), rand_slot(0)};
        load_lines(lines);
        ready_mode = 1;
        start_run(6);
        repeat (7) @(posedge clk);
        stall_cycles = 8;
        repeat (12) @(posedge clk);
        ready_mode = 2;
        wait_done("t3_done", 2000);
        ready_mode = 0;
        end_run("t3", 6);

        // FIFO runs dry mid-run
        do_reset();
        lines.delete();
        for (int i = 0; i < 5; i++) lines.push_back({rand_slot(0), rand_slot(0)});
        load_lines(lines);
        start_run(5);
        wait_pops(2, 200);
        @(posedge clk);
        #1 force_empty = 1'b1;
        repeat (2) @(negedge clk);
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_seen++;
        end
        check("t4_rd_en_while_empty", rd_seen, 0);
        @(posedge clk);
        #1 force_empty = 1'b0;
        wait_done("t4_done", 400);
        end_run("t4", 5);

        // zero-line run
        do_reset();
        exp_recs = 0;
        exp_lasts = 0;
        start_run(0);
        @(negedge clk);
        check("t5_done", done, 1'b1);
        repeat (3) @(negedge clk);
        end_run("t5", 0);

        // final line entirely filler: no record carries last
        do_reset();
        lines.delete();
        lines.push_back({rand_slot(0), rand_slot(0)});
        lines.push_back({LW{1'b0}});
        load_lines(lines);
        start_run(2);
        wait_done("t6_done", 200);
        end_run("t6", 2);

        // reset mid-run, then a fresh one-line run
        do_reset();
        lines.delete();
        for (int i = 0; i < 4; i++) lines.push_back({rand_slot(0), rand_slot(0)});
        load_lines(lines);
        start_run(4);
        wait_pops(2, 200);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 pops_at = pops;
        exp_q.delete();
        @(negedge clk);
        check("t7_rst_rd_en", fifo_rd_en, 1'b0);
        check("t7_rst_valid", rec_valid, 1'b0);
        check("t7_rst_last", rec_last, 1'b0);
        check("t7_rst_done", done, 1'b0);
        check("t7_rst_data", rec_data, '0);
        check("t7_rst_count", rec_count, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t7_no_pops", pops, SW'(pops_at));
        fifo_q.delete();
        pops = 0;
        lasts_seen = 0;
        lines.delete();
        lines.push_back({rand_slot(0), rand_slot(0)});
        load_lines(lines);
        start_run(1);
        wait_done("t7_done", 200);
        end_run("t7", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
